// File: rtl/slc3_ctrl_fsm_if.sv
// rtl/slc3_ctrl_fsm_if.sv - SLC-3 control bundle between IR/BEN decode inputs and datapath controls
interface slc3_ctrl_fsm_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_OE, Mem_WE
    );
endinterface

// File: rtl/slc3_ctrl_fsm.sv
// rtl/slc3_ctrl_fsm.sv - SLC-3 Moore control FSM with parametrised BRAM read/write wait states
module slc3_ctrl_fsm #(
    parameter int MEM_RD_LAT = 3,
    parameter int MEM_WR_LAT = 1,
    parameter int PAUSE_IR   = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    slc3_ctrl_fsm_if.master    ctl
);
    localparam int RD_W = ($clog2(MEM_RD_LAT + 1) > 1) ? $clog2(MEM_RD_LAT + 1) : 1;
    localparam int WR_W = ($clog2(MEM_WR_LAT + 1) > 1) ? $clog2(MEM_WR_LAT + 1) : 1;

    typedef enum logic [4:0] {
        HALTED, S18, RD, S35, PAUSE_IR1, PAUSE_IR2, S32,
        S1, S5, S9, S0, S22, S12, S4, S21, S20,
        S6, S7, S27, S23, WR, S13, S13B
    } state_t;

    state_t            state, next;
    logic [RD_W-1:0]   rd_cnt;
    logic [WR_W-1:0]   wr_cnt;
    logic              rd_ldr;  // RD return target: 0 fetch (S35), 1 LDR (S27)

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= HALTED;
            rd_cnt <= '0;
            wr_cnt <= '0;
            rd_ldr <= 1'b0;
        end else begin
            state <= next;
            if (state != RD && next == RD) begin
                rd_cnt <= RD_W'(MEM_RD_LAT);
                rd_ldr <= (state == S6);
            end else if (state == RD && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (state != WR && next == WR) begin
                wr_cnt <= WR_W'(MEM_WR_LAT - 1);
            end else if (state == WR && wr_cnt != '0) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        next           = state;
        ctl.LD_MAR     = 1'b0;
        ctl.LD_MDR     = 1'b0;
        ctl.LD_IR      = 1'b0;
        ctl.LD_BEN     = 1'b0;
        ctl.LD_CC      = 1'b0;
        ctl.LD_REG     = 1'b0;
        ctl.LD_PC      = 1'b0;
        ctl.LD_LED     = 1'b0;
        ctl.GatePC     = 1'b0;
        ctl.GateMDR    = 1'b0;
        ctl.GateALU    = 1'b0;
        ctl.GateMARMUX = 1'b0;
        ctl.PCMUX      = 2'b00;
        ctl.DRMUX      = 1'b0;
        ctl.SR1MUX     = 1'b0;
        ctl.SR2MUX     = 1'b0;
        ctl.ADDR1MUX   = 1'b0;
        ctl.ADDR2MUX   = 2'b00;
        ctl.ALUK       = 2'b00;
        ctl.Mem_OE     = 1'b0;
        ctl.Mem_WE     = 1'b0;

        unique case (state)
            HALTED: if (ctl.Run) next = S18;
            S18: begin
                ctl.GatePC = 1'b1;
                ctl.LD_MAR = 1'b1;
                ctl.LD_PC  = 1'b1;
                next       = RD;
            end
            RD: begin
                ctl.Mem_OE = 1'b1;
                if (rd_cnt == '0) begin
                    ctl.LD_MDR = 1'b1;
                    next       = rd_ldr ? S27 : S35;
                end
            end
            S35: begin
                ctl.GateMDR = 1'b1;
                ctl.LD_IR   = 1'b1;
                next        = (PAUSE_IR != 0) ? PAUSE_IR1 : S32;
            end
            PAUSE_IR1: begin
                ctl.LD_LED = 1'b1;
                if (ctl.Continue) next = PAUSE_IR2;
            end
            PAUSE_IR2: begin
                ctl.LD_LED = 1'b1;
                if (!ctl.Continue) next = S32;
            end
            S32: begin
                ctl.LD_BEN = 1'b1;
                case (ctl.Opcode)
                    4'b0001: next = S1;
                    4'b0101: next = S5;
                    4'b1001: next = S9;
                    4'b0000: next = S0;
                    4'b1100: next = S12;
                    4'b0100: next = S4;
                    4'b0110: next = S6;
                    4'b0111: next = S7;
                    4'b1101: next = S13;
                    default: next = S18;
                endcase
            end
            S1, S5, S9: begin
                ctl.ALUK    = (state == S1) ? 2'b00 : (state == S5) ? 2'b01 : 2'b10;
                ctl.SR2MUX  = (state != S9) && ctl.IR_5;
                ctl.GateALU = 1'b1;
                ctl.LD_REG  = 1'b1;
                ctl.LD_CC   = 1'b1;
                next        = S18;
            end
            S0: next = ctl.BEN ? S22 : S18;
            S22, S21: begin
                ctl.ADDR2MUX = (state == S22) ? 2'b10 : 2'b11;
                ctl.PCMUX    = 2'b10;
                ctl.LD_PC    = 1'b1;
                next         = S18;
            end
            S12, S20: begin
                ctl.ADDR1MUX = 1'b1;
                ctl.PCMUX    = 2'b10;
                ctl.LD_PC    = 1'b1;
                next         = S18;
            end
            S4: begin
                ctl.GatePC = 1'b1;
                ctl.DRMUX  = 1'b1;
                ctl.LD_REG = 1'b1;
                next       = ctl.IR_11 ? S21 : S20;
            end
            S6, S7: begin
                ctl.ADDR1MUX   = 1'b1;
                ctl.ADDR2MUX   = 2'b01;
                ctl.GateMARMUX = 1'b1;
                ctl.LD_MAR     = 1'b1;
                next           = (state == S6) ? RD : S23;
            end
            S27: begin
                ctl.GateMDR = 1'b1;
                ctl.LD_REG  = 1'b1;
                ctl.LD_CC   = 1'b1;
                next        = S18;
            end
            S23: begin
                ctl.SR1MUX  = 1'b1;
                ctl.ALUK    = 2'b11;
                ctl.GateALU = 1'b1;
                ctl.LD_MDR  = 1'b1;
                next        = WR;
            end
            WR: begin
                ctl.Mem_WE = 1'b1;
                if (wr_cnt == '0) next = S18;
            end
            S13: begin
                ctl.LD_LED = 1'b1;
                if (ctl.Continue) next = S13B;
            end
            S13B: begin
                ctl.LD_LED = 1'b1;
                if (!ctl.Continue) next = S18;
            end
            default: next = HALTED;
        endcase
    end
endmodule

// File: tb/tb_slc3_ctrl_fsm.sv
// tb/tb_slc3_ctrl_fsm.sv - directed self-checking bench for slc3_ctrl_fsm in three parameter sets
module tb_slc3_ctrl_fsm;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    slc3_ctrl_fsm_if if_d ();
    slc3_ctrl_fsm_if if_a ();
    slc3_ctrl_fsm_if if_p ();

    slc3_ctrl_fsm #(.MEM_RD_LAT(3), .MEM_WR_LAT(1), .PAUSE_IR(0)) u_d (.Clk(Clk), .Reset(Reset), .ctl(if_d));
    slc3_ctrl_fsm #(.MEM_RD_LAT(0), .MEM_WR_LAT(2), .PAUSE_IR(0)) u_a (.Clk(Clk), .Reset(Reset), .ctl(if_a));
    slc3_ctrl_fsm #(.MEM_RD_LAT(3), .MEM_WR_LAT(1), .PAUSE_IR(1)) u_p (.Clk(Clk), .Reset(Reset), .ctl(if_p));

    // {LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,LD_LED,GatePC,GateMDR,GateALU,GateMARMUX,
    //  PCMUX[1:0],DRMUX,SR1MUX,SR2MUX,ADDR1MUX,ADDR2MUX[1:0],ALUK[1:0],Mem_OE,Mem_WE}
    logic [23:0] o_d, o_a, o_p;
    assign o_d = {if_d.LD_MAR, if_d.LD_MDR, if_d.LD_IR, if_d.LD_BEN, if_d.LD_CC, if_d.LD_REG, if_d.LD_PC, if_d.LD_LED,
                  if_d.GatePC, if_d.GateMDR, if_d.GateALU, if_d.GateMARMUX, if_d.PCMUX, if_d.DRMUX, if_d.SR1MUX,
                  if_d.SR2MUX, if_d.ADDR1MUX, if_d.ADDR2MUX, if_d.ALUK, if_d.Mem_OE, if_d.Mem_WE};
    assign o_a = {if_a.LD_MAR, if_a.LD_MDR, if_a.LD_IR, if_a.LD_BEN, if_a.LD_CC, if_a.LD_REG, if_a.LD_PC, if_a.LD_LED,
                  if_a.GatePC, if_a.GateMDR, if_a.GateALU, if_a.GateMARMUX, if_a.PCMUX, if_a.DRMUX, if_a.SR1MUX,
                  if_a.SR2MUX, if_a.ADDR1MUX, if_a.ADDR2MUX, if_a.ALUK, if_a.Mem_OE, if_a.Mem_WE};
    assign o_p = {if_p.LD_MAR, if_p.LD_MDR, if_p.LD_IR, if_p.LD_BEN, if_p.LD_CC, if_p.LD_REG, if_p.LD_PC, if_p.LD_LED,
                  if_p.GatePC, if_p.GateMDR, if_p.GateALU, if_p.GateMARMUX, if_p.PCMUX, if_p.DRMUX, if_p.SR1MUX,
                  if_p.SR2MUX, if_p.ADDR1MUX, if_p.ADDR2MUX, if_p.ALUK, if_p.Mem_OE, if_p.Mem_WE};

    localparam logic [23:0] B_LD_MAR = 24'd1 << 23, B_LD_MDR = 24'd1 << 22, B_LD_IR  = 24'd1 << 21;
    localparam logic [23:0] B_LD_BEN = 24'd1 << 20, B_LD_CC  = 24'd1 << 19, B_LD_REG = 24'd1 << 18;
    localparam logic [23:0] B_LD_PC  = 24'd1 << 17, B_LD_LED = 24'd1 << 16, B_GPC    = 24'd1 << 15;
    localparam logic [23:0] B_GMDR   = 24'd1 << 14, B_GALU   = 24'd1 << 13, B_GMAR   = 24'd1 << 12;
    localparam logic [23:0] B_PC_ADD = 24'd2 << 10, B_DRMUX  = 24'd1 << 9,  B_SR1MUX = 24'd1 << 8;
    localparam logic [23:0] B_SR2MUX = 24'd1 << 7,  B_A1MUX  = 24'd1 << 6;
    localparam logic [23:0] B_A2_OFF6 = 24'd1 << 4, B_A2_OFF9 = 24'd2 << 4, B_A2_OFF11 = 24'd3 << 4;
    localparam logic [23:0] B_ALU_AND = 24'd1 << 2, B_ALU_NOT = 24'd2 << 2, B_ALU_PASS = 24'd3 << 2;
    localparam logic [23:0] B_OE = 24'd1 << 1, B_WE = 24'd1;

    localparam logic [23:0] E_HALT    = 24'd0;
    localparam logic [23:0] E_S18     = B_GPC | B_LD_MAR | B_LD_PC;
    localparam logic [23:0] E_RD      = B_OE;
    localparam logic [23:0] E_RD_LAST = B_OE | B_LD_MDR;
    localparam logic [23:0] E_S35     = B_GMDR | B_LD_IR;
    localparam logic [23:0] E_LED     = B_LD_LED;
    localparam logic [23:0] E_S32     = B_LD_BEN;
    localparam logic [23:0] E_S1_IMM  = B_SR2MUX | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S5_REG  = B_ALU_AND | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S9      = B_ALU_NOT | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S0      = 24'd0;
    localparam logic [23:0] E_S22     = B_A2_OFF9 | B_PC_ADD | B_LD_PC;
    localparam logic [23:0] E_S12     = B_A1MUX | B_PC_ADD | B_LD_PC;
    localparam logic [23:0] E_S4      = B_GPC | B_DRMUX | B_LD_REG;
    localparam logic [23:0] E_S21     = B_A2_OFF11 | B_PC_ADD | B_LD_PC;
    localparam logic [23:0] E_S6      = B_A1MUX | B_A2_OFF6 | B_GMAR | B_LD_MAR;
    localparam logic [23:0] E_S27     = B_GMDR | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_S23     = B_SR1MUX | B_ALU_PASS | B_GALU | B_LD_MDR;
    localparam logic [23:0] E_WR      = B_WE;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] obs_of(input int dut);
        case (dut)
            0:       return o_d;
            1:       return o_a;
            default: return o_p;
        endcase
    endfunction

    task automatic tick_chk(input int dut, input string tag, input logic [23:0] exp);
        @(posedge Clk);
        #1;
        check(tag, obs_of(dut), exp);
    endtask

    task automatic fetch_chk(input int dut, input int lat);
        for (int i = 0; i < lat; i++) tick_chk(dut, "rd_oe", E_RD);
        tick_chk(dut, "rd_mdr", E_RD_LAST);
        tick_chk(dut, "s35", E_S35);
        tick_chk(dut, "s32", E_S32);
    endtask

    initial begin
        {if_d.Run, if_d.Continue, if_d.Opcode, if_d.IR_5, if_d.IR_11, if_d.BEN} = '0;
        {if_a.Run, if_a.Continue, if_a.Opcode, if_a.IR_5, if_a.IR_11, if_a.BEN} = '0;
        {if_p.Run, if_p.Continue, if_p.Opcode, if_p.IR_5, if_p.IR_11, if_p.BEN} = '0;

        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("reset_d", o_d, E_HALT);
        check("reset_a", o_a, E_HALT);
        check("reset_p", o_p, E_HALT);
        Reset = 1'b0;
        tick_chk(0, "halt_no_run", E_HALT);

        // ADD imm: S18 counts as cycle 1, S1 lands on cycle 8
        if_d.Opcode = 4'b0001; if_d.IR_5 = 1'b1; if_d.Run = 1'b1;
        tick_chk(0, "add_s18", E_S18);
        if_d.Run = 1'b0;
        fetch_chk(0, 3);
        tick_chk(0, "add_s1", E_S1_IMM);
        tick_chk(0, "add_next_s18", E_S18);

        // Reset landing on the second RD cycle
        tick_chk(0, "rd_c1", E_RD);
        tick_chk(0, "rd_c2", E_RD);
        Reset = 1'b1;
        tick_chk(0, "reset_mid_rd", E_HALT);
        Reset = 1'b0;
        tick_chk(0, "halt_after_reset", E_HALT);
        if_d.Run = 1'b1;
        if_d.Opcode = 4'b0000; if_d.BEN = 1'b1;
        tick_chk(0, "restart_s18", E_S18);
        if_d.Run = 1'b0;

        fetch_chk(0, 3);
        tick_chk(0, "br_s0", E_S0);
        tick_chk(0, "br_taken_s22", E_S22);
        tick_chk(0, "br_taken_s18", E_S18);

        if_d.BEN = 1'b0;
        fetch_chk(0, 3);
        tick_chk(0, "br_nt_s0", E_S0);
        tick_chk(0, "br_nt_s18", E_S18);

        if_d.Opcode = 4'b0100; if_d.IR_11 = 1'b0;
        fetch_chk(0, 3);
        tick_chk(0, "jsrr_s4", E_S4);
        tick_chk(0, "jsrr_s20", E_S12);
        tick_chk(0, "jsrr_s18", E_S18);

        if_d.IR_11 = 1'b1;
        fetch_chk(0, 3);
        tick_chk(0, "jsr_s4", E_S4);
        tick_chk(0, "jsr_s21", E_S21);
        tick_chk(0, "jsr_s18", E_S18);

        if_d.Opcode = 4'b1100;
        fetch_chk(0, 3);
        tick_chk(0, "jmp_s12", E_S12);
        tick_chk(0, "jmp_s18", E_S18);

        if_d.Opcode = 4'b0101; if_d.IR_5 = 1'b0;
        fetch_chk(0, 3);
        tick_chk(0, "and_s5", E_S5_REG);
        tick_chk(0, "and_s18", E_S18);

        if_d.Opcode = 4'b1001; if_d.IR_5 = 1'b1;
        fetch_chk(0, 3);
        tick_chk(0, "not_s9", E_S9);
        tick_chk(0, "not_s18", E_S18);

        if_d.Opcode = 4'b0110;
        fetch_chk(0, 3);
        tick_chk(0, "ldr_s6", E_S6);
        for (int i = 0; i < 3; i++) tick_chk(0, "ldr_rd_oe", E_RD);
        tick_chk(0, "ldr_rd_mdr", E_RD_LAST);
        tick_chk(0, "ldr_s27", E_S27);
        tick_chk(0, "ldr_s18", E_S18);

        if_d.Opcode = 4'b0111;
        fetch_chk(0, 3);
        tick_chk(0, "str_s7", E_S6);
        tick_chk(0, "str_s23", E_S23);
        tick_chk(0, "str_wr", E_WR);
        tick_chk(0, "str_s18", E_S18);

        if_d.Opcode = 4'b1111;
        fetch_chk(0, 3);
        tick_chk(0, "nop_s18", E_S18);

        // Zero read latency, two-cycle write
        if_a.Opcode = 4'b0110; if_a.Run = 1'b1;
        tick_chk(1, "a_s18", E_S18);
        if_a.Run = 1'b0;
        fetch_chk(1, 0);
        tick_chk(1, "a_ldr_s6", E_S6);
        tick_chk(1, "a_ldr_rd", E_RD_LAST);
        tick_chk(1, "a_ldr_s27", E_S27);
        tick_chk(1, "a_ldr_s18", E_S18);
        if_a.Opcode = 4'b0111;
        fetch_chk(1, 0);
        tick_chk(1, "a_str_s7", E_S6);
        tick_chk(1, "a_str_s23", E_S23);
        tick_chk(1, "a_str_wr1", E_WR);
        tick_chk(1, "a_str_wr2", E_WR);
        tick_chk(1, "a_str_s18", E_S18);

        // IR pause plus PAUSE instruction
        if_p.Opcode = 4'b1101; if_p.Run = 1'b1;
        tick_chk(2, "p_s18", E_S18);
        if_p.Run = 1'b0;
        for (int i = 0; i < 3; i++) tick_chk(2, "p_rd_oe", E_RD);
        tick_chk(2, "p_rd_mdr", E_RD_LAST);
        tick_chk(2, "p_s35", E_S35);
        tick_chk(2, "p_pir1", E_LED);
        tick_chk(2, "p_pir1_hold", E_LED);
        tick_chk(2, "p_pir1_hold", E_LED);
        if_p.Continue = 1'b1;
        tick_chk(2, "p_pir2", E_LED);
        tick_chk(2, "p_pir2_hold", E_LED);
        if_p.Continue = 1'b0;
        tick_chk(2, "p_s32", E_S32);
        tick_chk(2, "p_s13", E_LED);
        tick_chk(2, "p_s13_hold", E_LED);
        if_p.Continue = 1'b1;
        tick_chk(2, "p_s13b", E_LED);
        if_p.Continue = 1'b0;
        tick_chk(2, "p_s13b_s18", E_S18);

        if_p.Opcode = 4'b1111; if_p.Continue = 1'b1;
        for (int i = 0; i < 3; i++) tick_chk(2, "p_rd_oe", E_RD);
        tick_chk(2, "p_rd_mdr", E_RD_LAST);
        tick_chk(2, "p_s35", E_S35);
        tick_chk(2, "p_pir1_fast", E_LED);
        tick_chk(2, "p_pir2_fast", E_LED);
        if_p.Continue = 1'b0;
        tick_chk(2, "p_nop_s32", E_S32);
        tick_chk(2, "p_nop_s18", E_S18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
